// File: rtl/stopwatch_pkg.sv
// stopwatch_pkg: shared constants and types for lap_stopwatch.
//   DIGIT_W    - bits per BCD-style digit
//   DIGIT_MOD  - digit moduli, element 0 is the least-significant digit
//   sw_state_t - run/stop state encoding
//   digit_mod  - modulus lookup for a digit position
package stopwatch_pkg;

    localparam int unsigned DIGIT_W    = 4;
    localparam int unsigned MAX_DIGITS = 8;

    // Listed MSD first so that DIGIT_MOD[0] is the LSD: 10,10,10,6,10,6,10,10.
    localparam logic [MAX_DIGITS-1:0][DIGIT_W-1:0] DIGIT_MOD = {
        4'd10, 4'd10, 4'd6, 4'd10, 4'd6, 4'd10, 4'd10, 4'd10
    };

    typedef enum logic [0:0] {
        STOPPED = 1'b0,
        RUNNING = 1'b1
    } sw_state_t;

    function automatic int unsigned digit_mod(input int unsigned idx);
        if (idx < MAX_DIGITS) begin
            return int'(DIGIT_MOD[idx]);
        end
        return 10;
    endfunction

endpackage

// File: rtl/digit_counter.sv
// digit_counter: one modulo-MOD digit of the stopwatch chain.
//   clk    - system clock
//   reset  - asynchronous active-low reset
//   clear  - synchronous zero, wins over inc
//   inc    - advance by one this cycle (wraps MOD-1 -> 0)
//   count  - current digit value
//   at_max - count equals MOD-1, feeds the carry chain
module digit_counter
    import stopwatch_pkg::*;
#(
    parameter int unsigned MOD = 10
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               clear,
    input  logic               inc,
    output logic [DIGIT_W-1:0] count,
    output logic               at_max
);

    localparam logic [DIGIT_W-1:0] MAX_VAL = DIGIT_W'(MOD - 1);

    logic [DIGIT_W-1:0] count_q;
    logic [DIGIT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (inc) begin
            count_d = (count_q == MAX_VAL) ? '0 : count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count  = count_q;
    assign at_max = (count_q == MAX_VAL);

endmodule

// File: rtl/lap_stopwatch.sv
// lap_stopwatch: multi-digit stopwatch with prescaled tick and optional lap hold.
//   clk        - system clock
//   reset      - asynchronous active-low reset
//   start_stop - pulse, toggles STOPPED/RUNNING
//   clear      - pulse, zeroes time, prescaler, overflow and lap hold
//   lap        - pulse, toggles lap hold (only with STOPWATCH_LAP_EN defined)
//   digits     - displayed digits, digit i at [4i+3:4i], digit 0 is the LSD
//   running    - high while RUNNING
//   lap_active - high while the display is frozen
//   overflow   - sticky, set when the count wraps from all-max to all-zero
// Build option: define STOPWATCH_LAP_EN to build the lap hold register.
module lap_stopwatch
    import stopwatch_pkg::*;
#(
    parameter int unsigned TICK_DIV   = 1_000_000,
    parameter int unsigned NUM_DIGITS = 6
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start_stop,
    input  logic                          clear,
    input  logic                          lap,
    output logic [DIGIT_W*NUM_DIGITS-1:0] digits,
    output logic                          running,
    output logic                          lap_active,
    output logic                          overflow
);

    localparam int unsigned PRE_W = $clog2(TICK_DIV);
    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(TICK_DIV - 1);

    sw_state_t state_q;
    sw_state_t state_d;

    logic [PRE_W-1:0] presc_q;
    logic [PRE_W-1:0] presc_d;
    logic             tick;

    logic ovf_q;
    logic ovf_d;
    logic wrap;

    logic [NUM_DIGITS-1:0]         inc;
    logic [NUM_DIGITS-1:0]         at_max;
    logic [DIGIT_W*NUM_DIGITS-1:0] live;

    // Run/stop FSM
    always_comb begin
        state_d = state_q;
        if (start_stop) begin
            unique case (state_q)
                STOPPED: state_d = RUNNING;
                RUNNING: state_d = STOPPED;
                default: state_d = STOPPED;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= STOPPED;
        end else begin
            state_q <= state_d;
        end
    end

    assign running = (state_q == RUNNING);

    // Prescaler holds while stopped so the sub-digit remainder survives a pause.
    assign tick = (state_q == RUNNING) && (presc_q == PRE_MAX);

    always_comb begin
        presc_d = presc_q;
        if (clear) begin
            presc_d = '0;
        end else if (state_q == RUNNING) begin
            presc_d = tick ? '0 : presc_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_d;
        end
    end

    // Digit chain: digit i advances when tick is high and all lower digits sit at max.
    for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
        if (i == 0) begin : g_lsd
            assign inc[i] = tick;
        end else begin : g_upper
            assign inc[i] = inc[i-1] & at_max[i-1];
        end

        digit_counter #(
            .MOD(digit_mod(i))
        ) u_digit (
            .clk   (clk),
            .reset (reset),
            .clear (clear),
            .inc   (inc[i]),
            .count (live[DIGIT_W*i +: DIGIT_W]),
            .at_max(at_max[i])
        );
    end

    // Carry out of the top digit means every digit was at max on this tick.
    assign wrap = inc[NUM_DIGITS-1] & at_max[NUM_DIGITS-1];

    always_comb begin
        ovf_d = ovf_q;
        if (clear) begin
            ovf_d = 1'b0;
        end else if (wrap) begin
            ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign overflow = ovf_q;

`ifdef STOPWATCH_LAP_EN
    logic                          lap_q;
    logic                          lap_d;
    logic [DIGIT_W*NUM_DIGITS-1:0] hold_q;
    logic [DIGIT_W*NUM_DIGITS-1:0] hold_d;

    // Lap is judged against the pre-toggle state when start_stop arrives alongside it.
    always_comb begin
        lap_d  = lap_q;
        hold_d = hold_q;
        if (clear) begin
            lap_d = 1'b0;
        end else if (lap) begin
            if (lap_q) begin
                lap_d = 1'b0;
            end else if (state_q == RUNNING) begin
                lap_d  = 1'b1;
                hold_d = live;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lap_q  <= 1'b0;
            hold_q <= '0;
        end else begin
            lap_q  <= lap_d;
            hold_q <= hold_d;
        end
    end

    assign lap_active = lap_q;
    assign digits     = lap_q ? hold_q : live;
`else
    logic unused_lap;
    assign unused_lap = lap;

    assign lap_active = 1'b0;
    assign digits     = live;
`endif

endmodule

// File: tb/tb_lap_stopwatch.sv
// tb_lap_stopwatch: scoreboard bench for lap_stopwatch.
// dut_a: TICK_DIV=4, NUM_DIGITS=6. dut_b: TICK_DIV=2, NUM_DIGITS=4 (carry/overflow).
// Stimulus pushes expected outputs; a negedge monitor pops and compares.
module tb_lap_stopwatch;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        ss_a = 1'b0, clr_a = 1'b0, lp_a = 1'b0;
    logic        ss_b = 1'b0, clr_b = 1'b0, lp_b = 1'b0;
    logic [23:0] digits_a;
    logic [15:0] digits_b;
    logic        run_a, lapact_a, ovf_a;
    logic        run_b, lapact_b, ovf_b;

    always #5 clk = ~clk;

    lap_stopwatch #(
        .TICK_DIV  (4),
        .NUM_DIGITS(6)
    ) dut_a (
        .clk       (clk),
        .reset     (reset),
        .start_stop(ss_a),
        .clear     (clr_a),
        .lap       (lp_a),
        .digits    (digits_a),
        .running   (run_a),
        .lap_active(lapact_a),
        .overflow  (ovf_a)
    );

    lap_stopwatch #(
        .TICK_DIV  (2),
        .NUM_DIGITS(4)
    ) dut_b (
        .clk       (clk),
        .reset     (reset),
        .start_stop(ss_b),
        .clear     (clr_b),
        .lap       (lp_b),
        .digits    (digits_b),
        .running   (run_b),
        .lap_active(lapact_b),
        .overflow  (ovf_b)
    );

    typedef struct packed {
        logic        sel;
        logic [31:0] dig;
        logic        run;
        logic        lapa;
        logic        ovf;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];
    int    checks = 0;
    int    errors = 0;

    task automatic push_exp(input string nm, input logic sel, input logic [31:0] d,
                            input logic r, input logic l, input logic o);
        exp_t e;
        e.sel  = sel;
        e.dig  = d;
        e.run  = r;
        e.lapa = l;
        e.ovf  = o;
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    task automatic pulse_a(input logic ss, input logic cl, input logic lp);
        @(posedge clk);
        #1;
        ss_a = ss; clr_a = cl; lp_a = lp;
        @(posedge clk);
        #1;
        ss_a = 1'b0; clr_a = 1'b0; lp_a = 1'b0;
    endtask

    task automatic pulse_b(input logic ss, input logic cl, input logic lp);
        @(posedge clk);
        #1;
        ss_b = ss; clr_b = cl; lp_b = lp;
        @(posedge clk);
        #1;
        ss_b = 1'b0; clr_b = 1'b0; lp_b = 1'b0;
    endtask

    // Monitor
    exp_t        mon_e;
    string       mon_n;
    logic [31:0] act_d;
    logic        act_r, act_l, act_o;

    always @(negedge clk) begin
        while (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            mon_n = name_q.pop_front();
            if (mon_e.sel == 1'b0) begin
                act_d = {8'h00, digits_a};
                act_r = run_a; act_l = lapact_a; act_o = ovf_a;
            end else begin
                act_d = {16'h0000, digits_b};
                act_r = run_b; act_l = lapact_b; act_o = ovf_b;
            end
            checks++;
            if (act_d !== mon_e.dig || act_r !== mon_e.run || act_l !== mon_e.lapa ||
                act_o !== mon_e.ovf) begin
                errors++;
                $display("FAIL %s: got digits=%h run=%b lap=%b ovf=%b, expected digits=%h run=%b lap=%b ovf=%b",
                         mon_n, act_d, act_r, act_l, act_o,
                         mon_e.dig, mon_e.run, mon_e.lapa, mon_e.ovf);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        errors++;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        push_exp("reset_a", 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        push_exp("reset_b", 1'b1, 32'h0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        #2;
        reset = 1'b1;

        // Run 40 cycles at TICK_DIV=4: ten increments
        pulse_a(1'b1, 1'b0, 1'b0);
        repeat (40) @(posedge clk);
        push_exp("run40", 1'b0, 32'h10, 1'b1, 1'b0, 1'b0);

        // Stop with prescaler at 2, then hold while stopped
        pulse_a(1'b1, 1'b0, 1'b0);
        push_exp("stopped", 1'b0, 32'h10, 1'b0, 1'b0, 1'b0);
        repeat (20) @(posedge clk);
        push_exp("stopped_hold", 1'b0, 32'h10, 1'b0, 1'b0, 1'b0);

        // Resume: remainder preserved, increment two cycles after running rises
        pulse_a(1'b1, 1'b0, 1'b0);
        @(posedge clk);
        push_exp("resume_plus1", 1'b0, 32'h10, 1'b1, 1'b0, 1'b0);
        @(posedge clk);
        push_exp("resume_plus2", 1'b0, 32'h11, 1'b1, 1'b0, 1'b0);

        // Clear while running restarts from zero with prescaler reset
        pulse_a(1'b0, 1'b1, 1'b0);
        push_exp("clear_run", 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        push_exp("clear_plus3", 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        @(posedge clk);
        push_exp("clear_plus4", 1'b0, 32'h1, 1'b1, 1'b0, 1'b0);

        // clear + lap + start_stop while running
        pulse_a(1'b1, 1'b1, 1'b1);
        push_exp("simul", 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        repeat (10) @(posedge clk);
        push_exp("simul_hold", 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);

        // Lap hold at 0x000123 (123 increments * 4 cycles)
        pulse_a(1'b1, 1'b0, 1'b0);
        repeat (492) @(posedge clk);
        push_exp("reach_123", 1'b0, 32'h123, 1'b1, 1'b0, 1'b0);
        pulse_a(1'b0, 1'b0, 1'b1);
`ifdef STOPWATCH_LAP_EN
        push_exp("lap_on", 1'b0, 32'h123, 1'b1, 1'b1, 1'b0);
`else
        push_exp("lap_on", 1'b0, 32'h123, 1'b1, 1'b0, 1'b0);
`endif
        repeat (20) @(posedge clk);
`ifdef STOPWATCH_LAP_EN
        push_exp("lap_frozen", 1'b0, 32'h123, 1'b1, 1'b1, 1'b0);
`else
        push_exp("lap_frozen", 1'b0, 32'h128, 1'b1, 1'b0, 1'b0);
`endif
        pulse_a(1'b0, 1'b0, 1'b1);
        push_exp("lap_off", 1'b0, 32'h129, 1'b1, 1'b0, 1'b0);

        // Carry chain / overflow at TICK_DIV=2, NUM_DIGITS=4
        pulse_b(1'b1, 1'b0, 1'b0);
        repeat (11998) @(posedge clk);
        push_exp("b_5999", 1'b1, 32'h5999, 1'b1, 1'b0, 1'b0);
        @(posedge clk);
        push_exp("b_5999_hold", 1'b1, 32'h5999, 1'b1, 1'b0, 1'b0);
        @(posedge clk);
        push_exp("b_wrap", 1'b1, 32'h0000, 1'b1, 1'b0, 1'b1);
        repeat (10) @(posedge clk);
        push_exp("b_ovf_sticky", 1'b1, 32'h0005, 1'b1, 1'b0, 1'b1);
        pulse_b(1'b0, 1'b1, 1'b0);
        push_exp("b_clear", 1'b1, 32'h0000, 1'b1, 1'b0, 1'b0);

        // Asynchronous reset between clock edges
        repeat (3) @(posedge clk);
        #2;
        reset = 1'b0;
        push_exp("async_a", 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        push_exp("async_b", 1'b1, 32'h0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expectations, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
